// File: rtl/dp_datapath_unit.sv
// -----------------------------------------------------------------------------
// dp_datapath_unit
//
// Datapath responder for the dedicated microprocessor's control unit. Each
// cycle the control unit presents one control word (a set of strobes). The
// datapath executes every strobe of the word on the same rising edge against
// registers X, Y and Z through an add/subtract ALU. It reports the zero status
// of Z back to the control unit.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer holds valid and its data stable until that transfer.
//   The input port asserts ready only on a cycle where the operand is actually
//   consumed. The output port is a one-entry buffer: out_valid stays high
//   until the consumer raises out_ready.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   clr_x, load_x       X <= 0 (has priority) / X <= ALU result
//   load_y              Y <= in_data; only acts together with in_z
//   load_z              with in_z: Z <= in_data; without in_z: Z <= Z - 1
//   in_z                this control word consumes one input operand
//   subtract            ALU mode: 1 = X - Y, 0 = X + Y
//   stat_done           push pre-edge X into the output buffer
//   in_data/valid/ready operand input port
//   out_data/valid/ready result output port (one-entry buffer)
//   zero                1 when Z == 0
//   ovf                 sticky carry/borrow from executed load_x
//   stall               the current control word is not executed; hold it
// -----------------------------------------------------------------------------
module dp_datapath_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_x,
    input  logic             load_x,
    input  logic             load_y,
    input  logic             load_z,
    input  logic             in_z,
    input  logic             subtract,
    input  logic             stat_done,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             ovf,
    output logic             stall
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   alu_full;
    logic             alu_flag;
    logic             stall_in;
    logic             stall_out;
    logic             stall_w;
    logic             push;
    logic             pop;

    always_comb begin
        // The ALU is one bit wider than the registers. The top bit is the add
        // carry-out, or the subtract borrow (set exactly when X < Y).
        alu_full = subtract ? ({1'b0, x_q} - {1'b0, y_q})
                            : ({1'b0, x_q} + {1'b0, y_q});
        alu_flag = alu_full[WIDTH];

        stall_in  = in_z & ~in_valid;
        stall_out = stat_done & out_valid_q & ~out_ready;
        stall_w   = stall_in | stall_out;

        push = stat_done & ~stall_w;
        pop  = out_valid_q & out_ready;

        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (!stall_w) begin
            if (clr_x) begin
                x_d   = '0;
                ovf_d = 1'b0;
            end else if (load_x) begin
                x_d = alu_full[WIDTH-1:0];
                if (alu_flag) begin
                    ovf_d = 1'b1;
                end
            end

            if (load_y && in_z) begin
                y_d = in_data;
            end

            if (load_z) begin
                if (in_z) begin
                    z_d = in_data;
                end else begin
                    z_d = z_q - WIDTH'(1);
                end
            end
        end

        // The output buffer may still drain while the word is stalled.
        if (push) begin
            out_data_d  = x_q;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (reset) begin
            x_d         = '0;
            y_d         = '0;
            z_d         = '0;
            ovf_d       = 1'b0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        x_q         <= x_d;
        y_q         <= y_d;
        z_q         <= z_d;
        ovf_q       <= ovf_d;
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
    end

    // During reset nothing executes, so no stall is reported and no operand
    // is accepted.
    assign stall     = stall_w & ~reset;
    assign in_ready  = in_z & in_valid & ~stall_out & ~reset;
    assign zero      = (z_q == '0);
    assign ovf       = ovf_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dp_datapath_unit.sv
module tb_dp_datapath_unit;

  localparam int WIDTH = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             clr_x, load_x, load_y, load_z, in_z, subtract, stat_done;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             ovf;
  logic             stall;

  int n_checks = 0;
  int n_fail   = 0;

  dp_datapath_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr_x     (clr_x),
    .load_x    (load_x),
    .load_y    (load_y),
    .load_z    (load_z),
    .in_z      (in_z),
    .subtract  (subtract),
    .stat_done (stat_done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .ovf       (ovf),
    .stall     (stall)
  );

  // driver tasks
  task automatic word(input logic c_clr, input logic c_lx, input logic c_ly,
                      input logic c_lz, input logic c_inz, input logic c_sub,
                      input logic c_done, input logic [WIDTH-1:0] c_data);
    clr_x     = c_clr;
    load_x    = c_lx;
    load_y    = c_ly;
    load_z    = c_lz;
    in_z      = c_inz;
    subtract  = c_sub;
    stat_done = c_done;
    in_data   = c_data;
  endtask

  task automatic idle();
    word(0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Inputs change 1 time unit after the rising edge, so every check sits
  // mid-cycle, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    idle();
    tick();
    tick();

    // reset state
    chk("rst_x", 32'(dut.x_q), 32'h0);
    chk("rst_y", 32'(dut.y_q), 32'h0);
    chk("rst_z", 32'(dut.z_q), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);

    // every strobe driven while reset is held
    in_valid = 1'b1;
    word(0, 1, 1, 1, 1, 0, 1, 8'h55);
    #1;
    chk("rst_strobe_in_ready", 32'(in_ready), 32'h0);
    chk("rst_strobe_stall", 32'(stall), 32'h0);
    tick();
    chk("rst_strobe_x", 32'(dut.x_q), 32'h0);
    chk("rst_strobe_y", 32'(dut.y_q), 32'h0);
    chk("rst_strobe_z", 32'(dut.z_q), 32'h0);
    chk("rst_strobe_out_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    idle();
    tick();

    // multiply 5 x 3
    word(1, 0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    word(0, 0, 1, 0, 1, 0, 0, 8'd5);
    #1;
    chk("mul_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("mul_y", 32'(dut.y_q), 32'd5);
    word(0, 0, 0, 1, 1, 0, 0, 8'd3);
    tick();
    chk("mul_z", 32'(dut.z_q), 32'd3);
    chk("mul_zero_init", 32'(zero), 32'h0);
    word(0, 1, 0, 1, 0, 0, 0, 8'h00);
    tick();
    chk("mul_x1", 32'(dut.x_q), 32'd5);
    chk("mul_z1", 32'(dut.z_q), 32'd2);
    tick();
    chk("mul_x2", 32'(dut.x_q), 32'd10);
    chk("mul_zero2", 32'(zero), 32'h0);
    tick();
    chk("mul_x3", 32'(dut.x_q), 32'd15);
    chk("mul_zero3", 32'(zero), 32'h1);
    word(0, 0, 0, 0, 0, 0, 1, 8'h00);
    tick();
    chk("mul_out_data", 32'(out_data), 32'd15);
    chk("mul_out_valid", 32'(out_valid), 32'h1);
    chk("mul_ovf", 32'(ovf), 32'h0);
    idle();
    out_ready = 1'b1;
    tick();
    chk("mul_pop_valid", 32'(out_valid), 32'h0);
    chk("mul_pop_data_hold", 32'(out_data), 32'd15);
    out_ready = 1'b0;

    // input stall
    in_valid = 1'b0;
    word(0, 0, 1, 0, 1, 0, 0, 8'h2A);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("install_stall", 32'(stall), 32'h1);
      chk("install_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("install_y_hold", 32'(dut.y_q), 32'd5);
    end
    in_valid = 1'b1;
    #1;
    chk("install_release_stall", 32'(stall), 32'h0);
    chk("install_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("install_y", 32'(dut.y_q), 32'h2A);
    idle();
    #1;
    chk("install_ready_drop", 32'(in_ready), 32'h0);

    // output backpressure
    word(1, 0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    word(0, 0, 1, 0, 1, 0, 0, 8'd7);
    tick();
    word(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    chk("bp_x7", 32'(dut.x_q), 32'd7);
    word(0, 0, 0, 0, 0, 0, 1, 8'h00);
    tick();
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_out_data7", 32'(out_data), 32'd7);
    word(0, 0, 1, 0, 1, 0, 0, 8'd2);
    tick();
    word(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    chk("bp_x9", 32'(dut.x_q), 32'd9);
    word(0, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall", 32'(stall), 32'h1);
      tick();
      chk("bp_out_data_hold", 32'(out_data), 32'd7);
      chk("bp_out_valid_hold", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_stall", 32'(stall), 32'h0);
    tick();
    chk("bp_pushpop_data", 32'(out_data), 32'd9);
    chk("bp_pushpop_valid", 32'(out_valid), 32'h1);
    idle();
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    chk("bp_ovf", 32'(ovf), 32'h0);

    // arithmetic boundaries
    word(1, 0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    word(0, 0, 1, 0, 1, 0, 0, 8'hF0);
    tick();
    word(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    word(0, 0, 1, 0, 1, 0, 0, 8'h20);
    tick();
    word(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    chk("ari_add_x", 32'(dut.x_q), 32'h10);
    chk("ari_add_ovf", 32'(ovf), 32'h1);
    idle();
    tick();
    chk("ari_ovf_sticky", 32'(ovf), 32'h1);
    word(1, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    chk("ari_clr_x", 32'(dut.x_q), 32'h0);
    chk("ari_clr_ovf", 32'(ovf), 32'h0);
    word(0, 0, 1, 0, 1, 0, 0, 8'd3);
    tick();
    word(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick();
    word(0, 0, 1, 0, 1, 0, 0, 8'd5);
    tick();
    word(0, 1, 0, 0, 0, 1, 0, 8'h00);
    tick();
    chk("ari_sub_x", 32'(dut.x_q), 32'hFE);
    chk("ari_sub_ovf", 32'(ovf), 32'h1);
    word(0, 0, 0, 1, 0, 0, 0, 8'h00);
    tick();
    chk("ari_z_wrap", 32'(dut.z_q), 32'hFF);
    chk("ari_z_wrap_zero", 32'(zero), 32'h0);

    // reset mid-operation
    word(0, 0, 0, 1, 1, 0, 0, 8'd2);
    tick();
    word(0, 0, 0, 0, 0, 0, 1, 8'h00);
    tick();
    chk("midrst_pre_valid", 32'(out_valid), 32'h1);
    chk("midrst_pre_z", 32'(dut.z_q), 32'd2);
    reset = 1'b1;
    word(0, 1, 1, 0, 1, 0, 1, 8'h77);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_z", 32'(dut.z_q), 32'h0);
    chk("midrst_zero", 32'(zero), 32'h1);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    chk("midrst_y", 32'(dut.y_q), 32'h0);
    reset = 1'b0;
    idle();
    in_valid = 1'b0;
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
